id_stage: RTL and testbench

Instruction-decode stage of the scalar RV32I pipeline, between the fetch stage and the execute stage. It decodes the fetched instruction and drives the register-file read addresses. It also merges register-file read data with forwarded EX/WB results and registers the decoded bundle into the ID/EX pipeline register under a valid/ready handshake. Load-use interlock and branch flush are handled here.

---
 rtl/id_defs.sv | 81 ++++++++
 rtl/id_decoder.sv | 81 ++++++++
 rtl/id_stage.sv | 133 +++++++++++++
 tb/tb_id_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_defs.sv
// Shared decode definitions for the RV32I ID stage: opcodes,
// ALU op encodings, immediate formats and the decoded bundle.
package id_defs;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        alu_op_e     alu_op;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        illegal;
        logic        use_rs1;
        logic        use_rs2;
    } dec_t;

    function automatic logic [31:0] gen_imm(
        input imm_type_e t,
        input logic [31:0] i
    );
        case (t)
            IMM_I: gen_imm = {{20{i[31]}}, i[31:20]};
            IMM_S: gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B: gen_imm = {{19{i[31]}}, i[31], i[7],
                              i[30:25], i[11:8], 1'b0};
            IMM_U: gen_imm = {i[31:12], 12'b0};
            IMM_J: gen_imm = {{11{i[31]}}, i[31], i[19:12],
                              i[20], i[30:21], 1'b0};
            default: gen_imm = 32'h0;
        endcase
    endfunction

    // alt selects SUB/SRA; callers mask it where it is not an opcode bit.
    function automatic alu_op_e f3_alu(
        input logic [2:0] f3,
        input logic alt
    );
        unique case (f3)
            3'b000: f3_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001: f3_alu = ALU_SLL;
            3'b010: f3_alu = ALU_SLT;
            3'b011: f3_alu = ALU_SLTU;
            3'b100: f3_alu = ALU_XOR;
            3'b101: f3_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110: f3_alu = ALU_OR;
            3'b111: f3_alu = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: class flags, ALU op, immediate, rs-used flags.
// Ports: inst (in, 32-bit instruction), dec (out, decoded bundle).
module id_decoder
    import id_defs::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0] opc;
    logic [2:0] f3;
    imm_type_e  itype;
    logic       wr;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];

    always_comb begin
        dec   = '0;
        itype = IMM_R;
        wr    = 1'b0;
        unique case (1'b1)
            opc == OP: begin
                dec.alu_op  = f3_alu(f3, inst[30]);
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                wr          = 1'b1;
            end
            opc == OP_IMM: begin
                itype       = IMM_I;
                dec.alu_op  = f3_alu(f3, inst[30] & (f3 == 3'b101));
                dec.use_rs1 = 1'b1;
                wr          = 1'b1;
            end
            opc == LOAD: begin
                itype       = IMM_I;
                dec.is_load = 1'b1;
                dec.use_rs1 = 1'b1;
                wr          = 1'b1;
            end
            opc == STORE: begin
                itype        = IMM_S;
                dec.is_store = 1'b1;
                dec.use_rs1  = 1'b1;
                dec.use_rs2  = 1'b1;
            end
            opc == BRANCH: begin
                itype         = IMM_B;
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.use_rs2   = 1'b1;
            end
            opc == JAL: begin
                itype      = IMM_J;
                dec.is_jal = 1'b1;
                wr         = 1'b1;
            end
            opc == JALR: begin
                itype       = IMM_I;
                dec.is_jalr = 1'b1;
                dec.use_rs1 = 1'b1;
                wr          = 1'b1;
            end
            opc == LUI: begin
                itype      = IMM_U;
                dec.alu_op = ALU_PASS;
                wr         = 1'b1;
            end
            opc == AUIPC: begin
                itype = IMM_U;
                wr    = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm   = gen_imm(itype, inst);
        dec.rd    = wr ? inst[11:7] : 5'd0;
        dec.rd_we = wr & (inst[11:7] != 5'd0);
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: regfile addressing, EX/WB forwarding, load-use
// interlock, flush, and the ID/EX register under valid/ready.
// Ports: if_* fetch bundle in, id_ready_o back; id_reg*_raddr_o and
// regs_reg*_rdata_i to/from the regfile; ex_*/wb_* forwarding and
// hazard status; ex_flush_i redirect; ex_ready_i and id_* ID/EX bundle.
module id_stage
    import id_defs::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    input  logic [31:0]     if_inst_i,
    input  logic [31:0]     if_pc_i,
    output logic            id_ready_o,
    output logic [4:0]      id_reg1_raddr_o,
    output logic [4:0]      id_reg2_raddr_o,
    input  logic [XLEN-1:0] regs_reg1_rdata_i,
    input  logic [XLEN-1:0] regs_reg2_rdata_i,
    input  logic            ex_valid_i,
    input  logic            ex_rd_we_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            wb_rd_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    input  logic            ex_flush_i,
    input  logic            ex_ready_i,
    output logic            id_valid_o,
    output logic [31:0]     id_pc_o,
    output logic [XLEN-1:0] id_op1_o,
    output logic [XLEN-1:0] id_op2_o,
    output logic [31:0]     id_imm_o,
    output logic [4:0]      id_rd_o,
    output logic            id_rd_we_o,
    output logic [3:0]      id_alu_op_o,
    output logic            id_is_load_o,
    output logic            id_is_store_o,
    output logic            id_is_branch_o,
    output logic            id_is_jal_o,
    output logic            id_is_jalr_o,
    output logic            id_illegal_o,
    output logic [2:0]      id_funct3_o
);

    dec_t            dec;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            ex_fwd;
    logic            ex_ld;
    logic            stall;
    logic            adv;

    assign rs1             = if_inst_i[19:15];
    assign rs2             = if_inst_i[24:20];
    assign id_reg1_raddr_o = rs1;
    assign id_reg2_raddr_o = rs2;

    id_decoder u_dec (
        .inst (if_inst_i),
        .dec  (dec)
    );

    // A load in EX has no data yet: it can only stall, never forward.
    assign ex_fwd = ex_valid_i & ex_rd_we_i & ~ex_is_load_i;
    assign ex_ld  = ex_valid_i & ex_rd_we_i & ex_is_load_i
                  & (ex_rd_i != 5'd0);

    assign op1 = (rs1 == 5'd0) ? '0 :
                 (ex_fwd & (ex_rd_i == rs1)) ? ex_result_i :
                 (wb_rd_we_i & (wb_rd_i == rs1)) ? wb_wdata_i :
                 regs_reg1_rdata_i;

    assign op2 = (rs2 == 5'd0) ? '0 :
                 (ex_fwd & (ex_rd_i == rs2)) ? ex_result_i :
                 (wb_rd_we_i & (wb_rd_i == rs2)) ? wb_wdata_i :
                 regs_reg2_rdata_i;

    assign stall = if_valid_i & ex_ld
                 & ((dec.use_rs1 & (ex_rd_i == rs1))
                  | (dec.use_rs2 & (ex_rd_i == rs2)));

    assign adv        = ~id_valid_o | ex_ready_i;
    assign id_ready_o = ex_flush_i | (adv & ~stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_o     <= 1'b0;
            id_pc_o        <= RESET_PC;
            id_op1_o       <= '0;
            id_op2_o       <= '0;
            id_imm_o       <= '0;
            id_rd_o        <= '0;
            id_rd_we_o     <= 1'b0;
            id_alu_op_o    <= ALU_ADD;
            id_is_load_o   <= 1'b0;
            id_is_store_o  <= 1'b0;
            id_is_branch_o <= 1'b0;
            id_is_jal_o    <= 1'b0;
            id_is_jalr_o   <= 1'b0;
            id_illegal_o   <= 1'b0;
            id_funct3_o    <= '0;
        end else if (ex_flush_i) begin
            id_valid_o <= 1'b0;
        end else if (adv) begin
            if (stall) begin
                id_valid_o <= 1'b0;
            end else begin
                id_valid_o     <= if_valid_i;
                id_pc_o        <= if_pc_i;
                id_op1_o       <= op1;
                id_op2_o       <= op2;
                id_imm_o       <= dec.imm;
                id_rd_o        <= dec.rd;
                id_rd_we_o     <= dec.rd_we;
                id_alu_op_o    <= dec.alu_op;
                id_is_load_o   <= dec.is_load;
                id_is_store_o  <= dec.is_store;
                id_is_branch_o <= dec.is_branch;
                id_is_jal_o    <= dec.is_jal;
                id_is_jalr_o   <= dec.is_jalr;
                id_illegal_o   <= dec.illegal;
                id_funct3_o    <= if_inst_i[14:12];
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random
// stimulus against a behavioural model of the decode stage.
module tb_id_stage;

    localparam logic [31:0] RPC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic        ex_valid;
    logic        ex_we;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_op1;
    logic [31:0] id_op2;
    logic [31:0] id_imm;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic [3:0]  id_alu;
    logic        id_ld;
    logic        id_st;
    logic        id_br;
    logic        id_jal;
    logic        id_jalr;
    logic        id_ill;
    logic [2:0]  id_f3;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_valid_i        (if_valid),
        .if_inst_i         (if_inst),
        .if_pc_i           (if_pc),
        .id_ready_o        (id_ready),
        .id_reg1_raddr_o   (raddr1),
        .id_reg2_raddr_o   (raddr2),
        .regs_reg1_rdata_i (rf1),
        .regs_reg2_rdata_i (rf2),
        .ex_valid_i        (ex_valid),
        .ex_rd_we_i        (ex_we),
        .ex_is_load_i      (ex_load),
        .ex_rd_i           (ex_rd),
        .ex_result_i       (ex_res),
        .wb_rd_we_i        (wb_we),
        .wb_rd_i           (wb_rd),
        .wb_wdata_i        (wb_data),
        .ex_flush_i        (flush),
        .ex_ready_i        (ex_ready),
        .id_valid_o        (id_valid),
        .id_pc_o           (id_pc),
        .id_op1_o          (id_op1),
        .id_op2_o          (id_op2),
        .id_imm_o          (id_imm),
        .id_rd_o           (id_rd),
        .id_rd_we_o        (id_rd_we),
        .id_alu_op_o       (id_alu),
        .id_is_load_o      (id_ld),
        .id_is_store_o     (id_st),
        .id_is_branch_o    (id_br),
        .id_is_jal_o       (id_jal),
        .id_is_jalr_o      (id_jalr),
        .id_illegal_o      (id_ill),
        .id_funct3_o       (id_f3)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic [3:0]  alu;
        logic        ld;
        logic        st;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ill;
        logic [2:0]  f3;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t m;
    exp_t nx;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t rst_val();
        exp_t r;
        r    = '0;
        r.pc = RPC;
        return r;
    endfunction

    // Reference decode from the ISA tables, written arithmetically.
    function automatic void mdec(input logic [31:0] in, output exp_t d,
                                 output logic u1, output logic u2);
        logic [31:0] sx;
        logic [2:0]  f3;
        logic        wr;
        int          tab[8];
        tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        sx  = {32{in[31]}};
        f3  = in[14:12];
        d   = '0;
        u1  = 0;
        u2  = 0;
        wr  = 0;
        case (in[6:0])
            7'h33: begin
                d.alu = 4'(tab[f3]);
                if (in[30] && f3 == 0) d.alu = 1;
                if (in[30] && f3 == 5) d.alu = 7;
                u1 = 1; u2 = 1; wr = 1;
            end
            7'h13: begin
                d.alu = 4'(tab[f3]);
                if (in[30] && f3 == 5) d.alu = 7;
                d.imm = (sx << 12) | 32'(in[31:20]);
                u1 = 1; wr = 1;
            end
            7'h03: begin
                d.ld = 1; u1 = 1; wr = 1;
                d.imm = (sx << 12) | 32'(in[31:20]);
            end
            7'h23: begin
                d.st = 1; u1 = 1; u2 = 1;
                d.imm = (sx << 12) | (32'(in[31:25]) << 5)
                      | 32'(in[11:7]);
            end
            7'h63: begin
                d.br = 1; d.alu = 1; u1 = 1; u2 = 1;
                d.imm = (sx << 12) | (32'(in[7]) << 11)
                      | (32'(in[30:25]) << 5) | (32'(in[11:8]) << 1);
            end
            7'h6F: begin
                d.jal = 1; wr = 1;
                d.imm = (sx << 20) | (32'(in[19:12]) << 12)
                      | (32'(in[20]) << 11) | (32'(in[30:21]) << 1);
            end
            7'h67: begin
                d.jalr = 1; u1 = 1; wr = 1;
                d.imm = (sx << 12) | 32'(in[31:20]);
            end
            7'h37: begin
                d.alu = 10; wr = 1;
                d.imm = in & 32'hFFFF_F000;
            end
            7'h17: begin
                wr = 1;
                d.imm = in & 32'hFFFF_F000;
            end
            default: d.ill = 1;
        endcase
        d.f3    = f3;
        d.rd    = wr ? in[11:7] : 5'd0;
        d.rd_we = wr && in[11:7] != 0;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs,
                                        input logic [31:0] rf);
        if (rs == 0) return 0;
        if (ex_valid && ex_we && !ex_load && ex_rd == rs) return ex_res;
        if (wb_we && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    // Inputs are already driven; check combinational outputs and
    // work out what the ID/EX register must hold after the next edge.
    task automatic settle();
        exp_t d;
        logic u1, u2, stall, adv;
        logic [4:0] s1, s2;
        #1;
        mdec(if_inst, d, u1, u2);
        s1 = if_inst[19:15];
        s2 = if_inst[24:20];
        stall = if_valid && ex_valid && ex_load && ex_we && ex_rd != 0
             && ((u1 && ex_rd == s1) || (u2 && ex_rd == s2));
        adv = !m.valid || ex_ready;
        chk("ready", 32'(id_ready), 32'(flush || (adv && !stall)));
        chk("raddr1", 32'(raddr1), 32'(s1));
        chk("raddr2", 32'(raddr2), 32'(s2));
        nx = m;
        if (!rst_n) nx = rst_val();
        else if (flush) nx.valid = 0;
        else if (adv && stall) nx.valid = 0;
        else if (adv) begin
            nx       = d;
            nx.valid = if_valid;
            nx.pc    = if_pc;
            nx.op1   = fwd(s1, rf1);
            nx.op2   = fwd(s2, rf2);
        end
    endtask

    task automatic check_regs();
        chk("valid", 32'(id_valid), 32'(m.valid));
        if (m.valid) begin
            chk("pc", id_pc, m.pc);
            chk("op1", id_op1, m.op1);
            chk("op2", id_op2, m.op2);
            chk("imm", id_imm, m.imm);
            chk("rd", 32'(id_rd), 32'(m.rd));
            chk("rd_we", 32'(id_rd_we), 32'(m.rd_we));
            chk("alu", 32'(id_alu), 32'(m.alu));
            chk("flags", {26'd0, id_ld, id_st, id_br, id_jal, id_jalr,
                          id_ill},
                {26'd0, m.ld, m.st, m.br, m.jal, m.jalr, m.ill});
            chk("f3", 32'(id_f3), 32'(m.f3));
        end
    endtask

    task automatic clock();
        @(posedge clk);
        m = nx;
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle();
        if_valid = 0; if_inst = 32'h0000_0013; if_pc = 0;
        rf1 = 32'h1111_1111; rf2 = 32'h2222_2222;
        ex_valid = 0; ex_we = 0; ex_load = 0; ex_rd = 0; ex_res = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        if_valid = 1; if_inst = inst; if_pc = pc;
    endtask

    task automatic rand_in();
        logic [6:0] opcs[11];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                 7'h37, 7'h17, 7'h7F, 7'h0B};
        if_inst = $urandom;
        if_inst[6:0]   = opcs[$urandom_range(0, 10)];
        if_inst[11:7]  = 5'($urandom_range(0, 7));
        if_inst[19:15] = 5'($urandom_range(0, 7));
        if_inst[24:20] = 5'($urandom_range(0, 7));
        if_valid = $urandom_range(0, 3) != 0;
        if_pc    = $urandom & 32'hFFFF_FFFC;
        rf1      = $urandom;
        rf2      = $urandom;
        ex_valid = $urandom_range(0, 3) != 0;
        ex_we    = $urandom_range(0, 3) != 0;
        ex_load  = $urandom_range(0, 2) == 0;
        ex_rd    = 5'($urandom_range(0, 7));
        ex_res   = $urandom;
        wb_we    = $urandom_range(0, 1) != 0;
        wb_rd    = 5'($urandom_range(0, 7));
        wb_data  = $urandom;
        flush    = $urandom_range(0, 15) == 0;
        ex_ready = $urandom_range(0, 3) != 0;
    endtask

    initial begin
        idle();
        m = rst_val();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_pc", id_pc, RPC);
        chk("rst_alu", 32'(id_alu), 32'd0);
        chk("rst_ill", 32'(id_ill), 32'd0);
        rst_n = 1;

        issue(32'h0050_0093, 32'h100);
        settle(); clock();
        chk("addi_valid", 32'(id_valid), 32'd1);
        chk("addi_imm", id_imm, 32'd5);
        chk("addi_op1", id_op1, 32'd0);
        chk("addi_rd", 32'(id_rd), 32'd1);
        chk("addi_we", 32'(id_rd_we), 32'd1);
        chk("addi_pc", id_pc, 32'h100);

        issue(32'h0020_81B3, 32'h104);
        ex_valid = 1; ex_we = 1; ex_rd = 1; ex_res = 32'hA;
        wb_we = 1; wb_rd = 2; wb_data = 32'hB;
        settle(); clock();
        chk("fwd_op1", id_op1, 32'hA);
        chk("fwd_op2", id_op2, 32'hB);

        wb_rd = 1; wb_data = 32'hC;
        settle(); clock();
        chk("prio_op1", id_op1, 32'hA);
        chk("prio_op2", id_op2, 32'h2222_2222);

        idle();
        issue(32'h0002_8333, 32'h108);
        ex_valid = 1; ex_we = 1; ex_load = 1; ex_rd = 5;
        settle();
        chk("lu_ready0", 32'(id_ready), 32'd0);
        clock();
        chk("lu_bubble", 32'(id_valid), 32'd0);
        ex_valid = 0; ex_load = 0;
        wb_we = 1; wb_rd = 5; wb_data = 32'h55;
        settle();
        chk("lu_ready1", 32'(id_ready), 32'd1);
        clock();
        chk("lu_valid", 32'(id_valid), 32'd1);
        chk("lu_op1", id_op1, 32'h55);

        idle();
        issue(32'h0050_0093, 32'h10C);
        ex_ready = 0;
        repeat (3) begin
            settle();
            chk("bp_ready", 32'(id_ready), 32'd0);
            clock();
            chk("bp_pc", id_pc, 32'h108);
        end
        ex_ready = 1;
        settle();
        chk("bp_release", 32'(id_ready), 32'd1);
        clock();
        chk("bp_next_pc", id_pc, 32'h10C);

        issue(32'h0002_8333, 32'h110);
        ex_valid = 1; ex_we = 1; ex_load = 1; ex_rd = 5; flush = 1;
        settle();
        chk("fl_ready", 32'(id_ready), 32'd1);
        clock();
        chk("fl_valid", 32'(id_valid), 32'd0);

        idle();
        issue(32'h0000_007F, 32'h114);
        settle(); clock();
        chk("ill_flag", 32'(id_ill), 32'd1);
        chk("ill_we", 32'(id_rd_we), 32'd0);
        chk("ill_valid", 32'(id_valid), 32'd1);

        issue(32'hFE00_0EE3, 32'h200);
        settle(); clock();
        chk("beq_imm", id_imm, 32'hFFFF_FFFC);
        chk("beq_br", 32'(id_br), 32'd1);

        issue(32'hFE20_AFA3, 32'h204);
        settle(); clock();
        chk("sw_imm", id_imm, 32'hFFFF_FFFF);
        chk("sw_st", 32'(id_st), 32'd1);

        for (int i = 0; i < 2000; i++) begin
            rand_in(); settle(); clock();
        end

        idle();
        issue(32'h0050_0093, 32'h300);
        settle(); clock();
        rst_n = 0;
        #1;
        chk("arst_valid", 32'(id_valid), 32'd0);
        chk("arst_pc", id_pc, RPC);
        m = rst_val();
        settle(); clock();
        rst_n = 1;

        for (int i = 0; i < 1000; i++) begin
            rand_in(); settle(); clock();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
